// File: rtl/bcd_display_scanner_if.sv
// Signal bundle between a BCD digit source and the multiplexed 7-segment scanner.
// The source drives the digits and controls; the scanner returns segment and anode drives.
interface bcd_display_scanner_if #(
   parameter int NUM_DIGITS = 8
);
   logic [4*NUM_DIGITS-1:0] bcd_in;
   logic                    load;
   logic                    enable;
   logic                    blank_lz;
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   an_n;
   logic                    digit_err;
   logic                    frame_tick;

   modport master (
      output bcd_in, load, enable, blank_lz,
      input  seg_n, an_n, digit_err, frame_tick
   );

   modport slave (
      input  bcd_in, load, enable, blank_lz,
      output seg_n, an_n, digit_err, frame_tick
   );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner for a latched set of BCD digits,
// with leading-zero blanking, invalid-nibble flag and a dark guard cycle per digit slot.
module bcd_display_scanner #(
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE   = 50000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   bcd_display_scanner_if.slave  bus
);
   localparam int              IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int              PW         = $clog2(PRESCALE);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0]   INDEX_LAST = IW'(NUM_DIGITS - 1);

   typedef enum logic {ST_IDLE, ST_SCAN} state_t;

   state_t                  r_state, w_state_next;
   logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow_next;
   logic [PW-1:0]           r_presc, w_presc_next;
   logic [IW-1:0]           r_index, w_index_next;
   logic [6:0]              r_seg_n, w_seg_n_next;
   logic [NUM_DIGITS-1:0]   r_an_n, w_an_n_next;
   logic                    r_digit_err, w_digit_err_next;
   logic                    r_frame_tick, w_frame_tick_next;

   logic [3:0]              w_nib [NUM_DIGITS];
   logic [6:0]              w_seg_digit [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   w_nib_bad;
   logic [NUM_DIGITS-1:0]   w_blank;

   function automatic logic [6:0] f_seg7(input logic [3:0] nib);
      case (nib)
         4'd0:    f_seg7 = 7'h40;
         4'd1:    f_seg7 = 7'h79;
         4'd2:    f_seg7 = 7'h24;
         4'd3:    f_seg7 = 7'h30;
         4'd4:    f_seg7 = 7'h19;
         4'd5:    f_seg7 = 7'h12;
         4'd6:    f_seg7 = 7'h02;
         4'd7:    f_seg7 = 7'h78;
         4'd8:    f_seg7 = 7'h00;
         4'd9:    f_seg7 = 7'h10;
         default: f_seg7 = 7'h3F;
      endcase
   endfunction

   // A digit is blanked when it and every more significant nibble are zero; digit 0 never is.
   always_comb begin
      logic v_run;
      v_run   = 1'b1;
      w_blank = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         v_run      = v_run && (w_nib[i] == 4'd0);
         w_blank[i] = bus.blank_lz && v_run;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign w_nib[gi]       = r_shadow[4*gi +: 4];
         assign w_nib_bad[gi]   = (w_nib[gi] > 4'd9);
         assign w_seg_digit[gi] = w_blank[gi] ? 7'h7F : f_seg7(w_nib[gi]);
      end
   endgenerate

   always_comb begin
      w_state_next      = r_state;
      w_shadow_next     = bus.load ? bus.bcd_in : r_shadow;
      w_presc_next      = r_presc;
      w_index_next      = r_index;
      w_seg_n_next      = 7'h7F;
      w_an_n_next       = '1;
      w_frame_tick_next = 1'b0;
      w_digit_err_next  = |w_nib_bad;
      case (r_state)
         ST_IDLE: begin
            if (bus.load) w_state_next = ST_SCAN;
         end
         ST_SCAN: begin
            if (bus.enable) begin
               if (r_presc == PRESC_LAST) begin
                  w_presc_next = '0;
                  if (r_index == INDEX_LAST) begin
                     w_index_next      = '0;
                     w_frame_tick_next = 1'b1;
                  end else begin
                     w_index_next = r_index + 1'b1;
                  end
               end else begin
                  w_presc_next = r_presc + 1'b1;
               end
               // Prescaler count 0 is the dark guard slot between digits.
               if (r_presc != '0) begin
                  w_an_n_next[r_index] = 1'b0;
                  w_seg_n_next         = w_seg_digit[r_index];
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_shadow     <= '0;
         r_presc      <= '0;
         r_index      <= '0;
         r_seg_n      <= 7'h7F;
         r_an_n       <= '1;
         r_digit_err  <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_shadow     <= w_shadow_next;
         r_presc      <= w_presc_next;
         r_index      <= w_index_next;
         r_seg_n      <= w_seg_n_next;
         r_an_n       <= w_an_n_next;
         r_digit_err  <= w_digit_err_next;
         r_frame_tick <= w_frame_tick_next;
      end
   end

   assign bus.seg_n      = r_seg_n;
   assign bus.an_n       = r_an_n;
   assign bus.digit_err  = r_digit_err;
   assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with PRESCALE=4, NUM_DIGITS=8.
// Sample n is the n-th falling edge after the load edge; for n>=2 it shows scan step t=n-2.
module tb_bcd_display_scanner;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   typedef logic [6:0] seg_tbl_t [8];

   always #5 clk = ~clk;

   bcd_display_scanner_if #(.NUM_DIGITS(8)) bus ();

   bcd_display_scanner #(
      .NUM_DIGITS (8),
      .PRESCALE   (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Expected anode drive for scan step t: dark on slot count 0, else one-cold on the digit.
   function automatic logic [7:0] exp_an(input int t);
      logic [7:0] one;
      one = 8'h01;
      if (t % 4 == 0) return 8'hFF;
      return ~(one << ((t / 4) % 8));
   endfunction

   function automatic logic [6:0] exp_seg(input int t, input seg_tbl_t tbl);
      if (t % 4 == 0) return 7'h7F;
      return tbl[(t / 4) % 8];
   endfunction

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst      = 1'b1;
      bus.load = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_pulse(input logic [31:0] v);
      bus.bcd_in = v;
      bus.load   = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(3);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.an_n, bus.seg_n, bus.frame_tick, bus.digit_err} !== {8'hFF, 7'h7F, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_idle cycle %0d: got an=%h seg=%h tick=%b err=%b, want an=ff seg=7f tick=0 err=0",
                     c, bus.an_n, bus.seg_n, bus.frame_tick, bus.digit_err);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_scan();
      seg_tbl_t tbl;
      logic     tick_exp;
      tbl = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
      bus.blank_lz = 1'b0;
      load_pulse(32'h87654321);
      for (int n = 2; n <= 70; n++) begin
         @(negedge clk);
         tick_exp = (n % 32 == 1);
         n_checks++;
         if ({bus.an_n, bus.seg_n} !== {exp_an(n - 2), exp_seg(n - 2, tbl)}) begin
            n_errors++;
            $display("FAIL scan n=%0d: got an=%h seg=%h, want an=%h seg=%h",
                     n, bus.an_n, bus.seg_n, exp_an(n - 2), exp_seg(n - 2, tbl));
         end
         n_checks++;
         if (bus.frame_tick !== tick_exp) begin
            n_errors++;
            $display("FAIL frame_tick n=%0d: got %b want %b", n, bus.frame_tick, tick_exp);
         end
      end
      $display("test_scan done");
   endtask

   task automatic test_blanking();
      seg_tbl_t tbl_a, tbl_b;
      tbl_a = '{7'h12, 7'h40, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      tbl_b = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      bus.blank_lz = 1'b1;
      do_reset(2);
      load_pulse(32'h00000405);
      for (int n = 2; n <= 33; n++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.an_n, bus.seg_n} !== {exp_an(n - 2), exp_seg(n - 2, tbl_a)}) begin
            n_errors++;
            $display("FAIL blank_405 n=%0d: got an=%h seg=%h, want an=%h seg=%h",
                     n, bus.an_n, bus.seg_n, exp_an(n - 2), exp_seg(n - 2, tbl_a));
         end
      end
      do_reset(2);
      load_pulse(32'h00000000);
      for (int n = 2; n <= 33; n++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.an_n, bus.seg_n} !== {exp_an(n - 2), exp_seg(n - 2, tbl_b)}) begin
            n_errors++;
            $display("FAIL blank_zero n=%0d: got an=%h seg=%h, want an=%h seg=%h",
                     n, bus.an_n, bus.seg_n, exp_an(n - 2), exp_seg(n - 2, tbl_b));
         end
      end
      bus.blank_lz = 1'b0;
      $display("test_blanking done");
   endtask

   task automatic test_digit_err();
      seg_tbl_t tbl;
      tbl = '{7'h30, 7'h24, 7'h79, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      bus.blank_lz = 1'b1;
      do_reset(2);
      load_pulse(32'h0000A123);
      n_checks++;
      if (bus.digit_err !== 1'b0) begin
         n_errors++;
         $display("FAIL err_latency: got %b want 0", bus.digit_err);
      end
      for (int n = 2; n <= 33; n++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.an_n, bus.seg_n, bus.digit_err} !== {exp_an(n - 2), exp_seg(n - 2, tbl), 1'b1}) begin
            n_errors++;
            $display("FAIL err_scan n=%0d: got an=%h seg=%h err=%b, want an=%h seg=%h err=1",
                     n, bus.an_n, bus.seg_n, bus.digit_err, exp_an(n - 2), exp_seg(n - 2, tbl));
         end
      end
      load_pulse(32'h00000123);
      n_checks++;
      if (bus.digit_err !== 1'b1) begin
         n_errors++;
         $display("FAIL err_hold: got %b want 1", bus.digit_err);
      end
      @(negedge clk);
      n_checks++;
      if (bus.digit_err !== 1'b0) begin
         n_errors++;
         $display("FAIL err_clear: got %b want 0", bus.digit_err);
      end
      bus.blank_lz = 1'b0;
      $display("test_digit_err done");
   endtask

   task automatic test_enable();
      seg_tbl_t   tbl;
      logic [7:0] an_e;
      logic [6:0] seg_e;
      tbl = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
      do_reset(2);
      load_pulse(32'h87654321);
      for (int n = 2; n <= 42; n++) begin
         @(negedge clk);
         if (n <= 24) begin
            an_e  = exp_an(n - 2);
            seg_e = exp_seg(n - 2, tbl);
         end else if (n <= 34) begin
            an_e  = 8'hFF;
            seg_e = 7'h7F;
         end else begin
            an_e  = exp_an(n - 12);
            seg_e = exp_seg(n - 12, tbl);
         end
         n_checks++;
         if ({bus.an_n, bus.seg_n} !== {an_e, seg_e}) begin
            n_errors++;
            $display("FAIL enable n=%0d: got an=%h seg=%h, want an=%h seg=%h",
                     n, bus.an_n, bus.seg_n, an_e, seg_e);
         end
         if (n == 24) bus.enable = 1'b0;
         if (n == 34) bus.enable = 1'b1;
      end
      $display("test_enable done");
   endtask

   task automatic test_reset_mid();
      seg_tbl_t tbl;
      tbl = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
      do_reset(2);
      load_pulse(32'h87654321);
      repeat (26) @(negedge clk);
      n_checks++;
      if (bus.an_n !== 8'hBF) begin
         n_errors++;
         $display("FAIL mid_index6: got an=%h want bf", bus.an_n);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         n_checks++;
         if ({bus.an_n, bus.seg_n, bus.frame_tick, bus.digit_err} !== {8'hFF, 7'h7F, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL mid_reset cycle %0d: got an=%h seg=%h tick=%b err=%b, want ff 7f 0 0",
                     c, bus.an_n, bus.seg_n, bus.frame_tick, bus.digit_err);
         end
         @(negedge clk);
      end
      load_pulse(32'h12345678);
      for (int n = 2; n <= 33; n++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.an_n, bus.seg_n} !== {exp_an(n - 2), exp_seg(n - 2, tbl)}) begin
            n_errors++;
            $display("FAIL restart n=%0d: got an=%h seg=%h, want an=%h seg=%h",
                     n, bus.an_n, bus.seg_n, exp_an(n - 2), exp_seg(n - 2, tbl));
         end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      rst          = 1'b1;
      bus.load     = 1'b0;
      bus.enable   = 1'b1;
      bus.blank_lz = 1'b0;
      bus.bcd_in   = '0;
      test_reset();
      test_scan();
      test_blanking();
      test_digit_err();
      test_enable();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
